// File: rtl/nco_multi_pkg.sv
// Shared NCO constants, the shadow/active config record and the quarter-wave sine generator.
// Optional phase dither in nco_channel is enabled with `NCO_PHASE_DITHER_EN.
package nco_multi_pkg;
    localparam int config_reg_width = 32;
    localparam int sine_lut_width   = 10;
    localparam int word_width       = 16;
    localparam int nco_amp_width    = 16;
    localparam int nco_amp_unity    = 32768;

    typedef struct packed {
        logic [config_reg_width-1:0] ftw;
        logic [sine_lut_width-1:0]   phase;
        logic [nco_amp_width-1:0]    amp;
    } nco_cfg_t;

    localparam longint HALF_PI_Q30 = 64'd1686629713;

    // round((2^(w-1)-1) * sin(pi/2 * a/qn)), Taylor series in Q30; elaboration-time only.
    function automatic longint sine_q(input int a, input int qn, input int w);
        longint x, x2, term, sum, full, v;
        x    = (longint'(a) * HALF_PI_Q30) / longint'(qn);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 5; k++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1)));
            sum  = sum + term;
        end
        full = (longint'(1) << (w - 1)) - 1;
        v    = (sum * full + (longint'(1) << 29)) >>> 30;
        if (v > full) v = full;
        if (v < 0) v = 0;
        return v;
    endfunction
endpackage

// File: rtl/nco_channel.sv
// One NCO channel: accumulator, active config, index/LUT/scale pipeline.
// `NCO_PHASE_DITHER_EN adds an LFSR dither to the indexing path only.
module nco_channel import nco_multi_pkg::*; #(
    parameter int ACC_WIDTH = config_reg_width,
    parameter int LUT_WIDTH = sine_lut_width,
    parameter int OUT_WIDTH = word_width,
    parameter int AMP_WIDTH = nco_amp_width
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        commit_i,
    input  logic                        sync_i,
    input  nco_cfg_t                    shadow_i,
    output logic signed [OUT_WIDTH-1:0] sine_o,
    output logic signed [OUT_WIDTH-1:0] cosine_o
);
    localparam int FRAC = AMP_WIDTH - 1;
    localparam int PW   = OUT_WIDTH + AMP_WIDTH + 1;
    localparam logic [LUT_WIDTH-1:0] QUARTER = LUT_WIDTH'(1 << (LUT_WIDTH - 2));

    nco_cfg_t                    act_q, act_d;
    logic [ACC_WIDTH-1:0]        acc_q, acc_d, acc_ix;
    logic [LUT_WIDTH-1:0]        idx_s_d, idx_s_q, idx_c_q;
    logic [AMP_WIDTH-1:0]        amp1_q, amp2_q;
    logic signed [OUT_WIDTH-1:0] lut_s, lut_c, lut_s_q, lut_c_q, sin_q, cos_q;
    logic signed [PW-1:0]        prod_s, prod_c;

`ifdef NCO_PHASE_DITHER_EN
    localparam int DW = (ACC_WIDTH - LUT_WIDTH > 16) ? 16 : (ACC_WIDTH - LUT_WIDTH);
    logic [15:0] lfsr_q, lfsr_d;

    // Galois form of x^16+x^14+x^13+x^11+1; the stored accumulator is never dithered.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        acc_ix = acc_q + ACC_WIDTH'(lfsr_q[DW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (!rst) lfsr_q <= 16'hACE1;
        else      lfsr_q <= lfsr_d;
    end
`else
    assign acc_ix = acc_q;
`endif

    always_comb begin
        act_d   = commit_i ? shadow_i : act_q;
        acc_d   = sync_i ? '0 : (acc_q + act_q.ftw[ACC_WIDTH-1:0]);
        idx_s_d = acc_ix[ACC_WIDTH-1 -: LUT_WIDTH] + act_q.phase[LUT_WIDTH-1:0];
        prod_s  = lut_s_q * $signed({1'b0, amp2_q});
        prod_c  = lut_c_q * $signed({1'b0, amp2_q});
    end

    sine_lut #(.LUT_WIDTH(LUT_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_sin (.idx_i(idx_s_q), .data_o(lut_s));
    sine_lut #(.LUT_WIDTH(LUT_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_cos (.idx_i(idx_c_q), .data_o(lut_c));

    // Amplitude travels with its index so phase and amplitude changes land together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            act_q   <= '0;
            acc_q   <= '0;
            idx_s_q <= '0;
            idx_c_q <= '0;
            amp1_q  <= '0;
            amp2_q  <= '0;
            lut_s_q <= '0;
            lut_c_q <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
        end else begin
            act_q   <= act_d;
            acc_q   <= acc_d;
            idx_s_q <= idx_s_d;
            idx_c_q <= idx_s_d + QUARTER;
            amp1_q  <= act_q.amp[AMP_WIDTH-1:0];
            amp2_q  <= amp1_q;
            lut_s_q <= lut_s;
            lut_c_q <= lut_c;
            sin_q   <= prod_s[FRAC +: OUT_WIDTH];
            cos_q   <= prod_c[FRAC +: OUT_WIDTH];
        end
    end

    assign sine_o   = sin_q;
    assign cosine_o = cos_q;
endmodule

// File: rtl/sine_lut.sv
// Combinational full-wave sine lookup built from a quarter-wave table.
module sine_lut import nco_multi_pkg::*; #(
    parameter int LUT_WIDTH = sine_lut_width,
    parameter int OUT_WIDTH = word_width
) (
    input  logic [LUT_WIDTH-1:0]        idx_i,
    output logic signed [OUT_WIDTH-1:0] data_o
);
    localparam int QN     = 1 << (LUT_WIDTH - 2);
    localparam int ADDR_W = LUT_WIDTH - 1;

    logic [QN:0][OUT_WIDTH-1:0] rom;
    logic [1:0]                 quad;
    logic [ADDR_W-1:0]          ofs, addr;
    logic signed [OUT_WIDTH-1:0] mag;

    for (genvar i = 0; i <= QN; i++) begin : g_rom
        localparam longint V = sine_q(i, QN, OUT_WIDTH);
        assign rom[i] = V[OUT_WIDTH-1:0];
    end

    // Odd quadrants mirror the address, upper half negates; entry QN holds the peak.
    always_comb begin
        quad   = idx_i[LUT_WIDTH-1 -: 2];
        ofs    = {1'b0, idx_i[LUT_WIDTH-3:0]};
        addr   = quad[0] ? (ADDR_W'(QN) - ofs) : ofs;
        mag    = $signed(rom[addr]);
        data_o = quad[1] ? -mag : mag;
    end
endmodule

// File: rtl/nco_multi.sv
// Multi-channel NCO top: config handshake, shadow bank, commit/sync fan-out, cfg_err.
// Build with `NCO_PHASE_DITHER_EN to enable per-channel phase dither.
module nco_multi import nco_multi_pkg::*; #(
    parameter  int NUM_CH    = 2,
    parameter  int ACC_WIDTH = config_reg_width,
    parameter  int LUT_WIDTH = sine_lut_width,
    parameter  int OUT_WIDTH = word_width,
    parameter  int AMP_WIDTH = nco_amp_width,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [CH_W-1:0]               cfg_ch,
    input  logic [ACC_WIDTH-1:0]          cfg_ftw,
    input  logic [LUT_WIDTH-1:0]          cfg_phase,
    input  logic [AMP_WIDTH-1:0]          cfg_amp,
    input  logic                          cfg_commit,
    input  logic                          sync,
    output logic [NUM_CH*OUT_WIDTH-1:0]   sine_out,
    output logic [NUM_CH*OUT_WIDTH-1:0]   cosine_out,
    output logic                          out_valid,
    output logic                          cfg_err
);
    localparam logic [AMP_WIDTH-1:0] AMP_MAX = AMP_WIDTH'(nco_amp_unity);

    nco_cfg_t             shadow_q [NUM_CH];
    nco_cfg_t             shadow_d [NUM_CH];
    logic                 err_q, err_d;
    logic [2:0]           vld_pipe_q;
    logic                 wr_en, ch_ok;
    logic [AMP_WIDTH-1:0] amp_sat;

    // A write colliding with a commit is refused so the commit sees a stable bank.
    assign cfg_ready = rst & ~cfg_commit;
    assign wr_en     = cfg_valid & cfg_ready;
    assign ch_ok     = int'(cfg_ch) < NUM_CH;
    assign amp_sat   = (cfg_amp > AMP_MAX) ? AMP_MAX : cfg_amp;

    always_comb begin
        err_d = err_q | (wr_en & ~ch_ok);
        for (int c = 0; c < NUM_CH; c++) begin
            shadow_d[c] = shadow_q[c];
            if (wr_en && ch_ok && (int'(cfg_ch) == c)) begin
                shadow_d[c].ftw   = config_reg_width'(cfg_ftw);
                shadow_d[c].phase = sine_lut_width'(cfg_phase);
                shadow_d[c].amp   = nco_amp_width'(amp_sat);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q      <= 1'b0;
            vld_pipe_q <= '0;
            for (int c = 0; c < NUM_CH; c++) shadow_q[c] <= '0;
        end else begin
            err_q      <= err_d;
            vld_pipe_q <= {vld_pipe_q[1:0], 1'b1};
            for (int c = 0; c < NUM_CH; c++) shadow_q[c] <= shadow_d[c];
        end
    end

    assign out_valid = vld_pipe_q[2];
    assign cfg_err   = err_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        nco_channel #(
            .ACC_WIDTH(ACC_WIDTH),
            .LUT_WIDTH(LUT_WIDTH),
            .OUT_WIDTH(OUT_WIDTH),
            .AMP_WIDTH(AMP_WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .commit_i (cfg_commit),
            .sync_i   (sync),
            .shadow_i (shadow_q[c]),
            .sine_o   (sine_out[c*OUT_WIDTH +: OUT_WIDTH]),
            .cosine_o (cosine_out[c*OUT_WIDTH +: OUT_WIDTH])
        );
    end
endmodule

// File: tb/tb_nco_multi.sv
// Self-checking bench for nco_multi against a per-edge behavioural model (dither disabled).
module tb_nco_multi;
    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int LW  = 10;
    localparam int OW  = 16;
    localparam int MW  = 16;
    localparam int CW  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_valid = 1'b0, cfg_commit = 1'b0, sync = 1'b0;
    logic [CW-1:0]    cfg_ch = '0;
    logic [AW-1:0]    cfg_ftw = '0;
    logic [LW-1:0]    cfg_phase = '0;
    logic [MW-1:0]    cfg_amp = '0;
    logic             cfg_ready, out_valid, cfg_err;
    logic [NCH*OW-1:0] sine_out, cosine_out;

    nco_multi #(.NUM_CH(NCH)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_ftw(cfg_ftw), .cfg_phase(cfg_phase), .cfg_amp(cfg_amp),
        .cfg_commit(cfg_commit), .sync(sync), .sine_out(sine_out), .cosine_out(cosine_out),
        .out_valid(out_valid), .cfg_err(cfg_err)
    );

    always #2 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input longint obs, input longint exp, input int tol = 0);
        longint d;
        d = obs - exp;
        n_chk++;
        if (d < -tol || d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Architectural state: accumulators, shadow and active config, sticky error.
    typedef struct {
        longint acc [NCH];
        longint ph  [NCH];
        longint amp [NCH];
    } snap_t;

    longint m_acc [NCH];
    longint sh_ftw [NCH], sh_ph [NCH], sh_amp [NCH];
    longint ac_ftw [NCH], ac_ph [NCH], ac_amp [NCH];
    bit     m_err;
    int     m_vcnt;
    snap_t  hist[$];

    function automatic longint lut_ref(input longint idx);
        real v;
        v = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(idx) / 1024.0);
        return longint'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
    endfunction

    function automatic longint samp(input longint acc, input longint ph, input longint amp, input longint off);
        longint idx;
        idx = ((acc >> 22) + ph + off) % 1024;
        return (lut_ref(idx) * amp) >>> 15;
    endfunction

    function automatic snap_t zero_snap();
        snap_t s;
        for (int c = 0; c < NCH; c++) begin
            s.acc[c] = 0; s.ph[c] = 0; s.amp[c] = 0;
        end
        return s;
    endfunction

    task automatic clear_hist();
        hist.delete();
        for (int i = 0; i < 4; i++) hist.push_back(zero_snap());
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        snap_t s;
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_acc[c] = 0; sh_ftw[c] = 0; sh_ph[c] = 0; sh_amp[c] = 0;
                ac_ftw[c] = 0; ac_ph[c] = 0; ac_amp[c] = 0;
            end
            m_err  = 0;
            m_vcnt = 0;
            clear_hist();
            return;
        end
        for (int c = 0; c < NCH; c++)
            m_acc[c] = sync ? 0 : ((m_acc[c] + ac_ftw[c]) & 64'hFFFF_FFFF);
        if (cfg_commit)
            for (int c = 0; c < NCH; c++) begin
                ac_ftw[c] = sh_ftw[c]; ac_ph[c] = sh_ph[c]; ac_amp[c] = sh_amp[c];
            end
        if (cfg_valid && !cfg_commit) begin
            if (int'(cfg_ch) < NCH) begin
                sh_ftw[cfg_ch] = cfg_ftw;
                sh_ph[cfg_ch]  = cfg_phase;
                sh_amp[cfg_ch] = (cfg_amp > 32768) ? 32768 : cfg_amp;
            end else begin
                m_err = 1;
            end
        end
        if (m_vcnt < 3) m_vcnt++;
        for (int c = 0; c < NCH; c++) begin
            s.acc[c] = m_acc[c]; s.ph[c] = ac_ph[c]; s.amp[c] = ac_amp[c];
        end
        hist.push_back(s);
        void'(hist.pop_front());
    endtask

    task automatic tick();
        snap_t h;
        int tol;
        #1;
        chk("cfg_ready", cfg_ready, rst && !cfg_commit);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        h = hist[0];
        for (int c = 0; c < NCH; c++) begin
            tol = (h.amp[c] == 0) ? 0 : 1;
            chk($sformatf("sine_ch%0d", c), longint'($signed(sine_out[c*OW +: OW])),
                samp(h.acc[c], h.ph[c], h.amp[c], 0), tol);
            chk($sformatf("cosine_ch%0d", c), longint'($signed(cosine_out[c*OW +: OW])),
                samp(h.acc[c], h.ph[c], h.amp[c], 256), tol);
        end
        chk("out_valid", out_valid, m_vcnt >= 3);
        chk("cfg_err", cfg_err, m_err);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int ch, input longint ftw, input int ph, input int amp);
        cfg_valid = 1'b1; cfg_ch = CW'(ch); cfg_ftw = AW'(ftw);
        cfg_phase = LW'(ph); cfg_amp = MW'(amp);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    initial begin
        clear_hist();
        @(negedge clk);
        // reset state
        run(2);
        rst = 1'b1;

        // fill: ch0 steps one LUT entry per cycle at unity amplitude
        wr(0, 64'd1 << 22, 0, 32768);
        commit();
        run(8);

        // shadow isolation on ch1, then +2 per cycle after commit
        wr(1, 64'd1 << 23, 0, 32768);
        run(5);
        commit();
        run(6);

        // half amplitude, then clamped over-unity amplitude
        wr(0, 64'd1 << 22, 0, 16384);
        commit();
        run(5);
        wr(0, 64'd1 << 22, 0, 40000);
        commit();
        run(5);

        // quarter-turn phase offset mid-run
        wr(0, 64'd1 << 22, 256, 32768);
        commit();
        run(6);

        // sync + commit with a write held across the commit cycle
        wr(0, 64'd1 << 21, 0, 32768);
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_ftw = 32'h0100_0000;
        cfg_phase = 10'd10; cfg_amp = 16'd20000;
        cfg_commit = 1'b1; sync = 1'b1;
        tick();
        cfg_commit = 1'b0; sync = 1'b0;
        tick();
        cfg_valid = 1'b0;
        run(4);
        commit();
        run(6);

        // out-of-range channel: flagged, no channel touched
        wr(3, 64'hFFFF_FFFF, 511, 32768);
        commit();
        run(5);

        // mid-run reset discards uncommitted shadow data
        wr(1, 64'd1 << 24, 100, 32768);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        run(2);
        commit();
        run(6);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cfg_valid  = ($urandom_range(0, 2) == 0);
            cfg_ch     = CW'($urandom_range(0, 3));
            cfg_ftw    = AW'($urandom());
            cfg_phase  = LW'($urandom_range(0, 1023));
            cfg_amp    = MW'($urandom_range(0, 40000));
            cfg_commit = ($urandom_range(0, 7) == 0);
            sync       = ($urandom_range(0, 19) == 0);
            rst        = ($urandom_range(0, 199) != 0);
            tick();
        end
        cfg_valid = 1'b0; cfg_commit = 1'b0; sync = 1'b0; rst = 1'b1;
        run(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
